// File: rtl/gate_test_sequencer_if.sv
// gate_test_sequencer_if
// ----------------------
// Bundles the control and GUT-facing signals of gate_test_sequencer.
//
// Handshake: start acts as a request that is only looked at while the
// sequencer is idle (busy=0). A request with op<=5 is accepted on the
// rising edge. From that edge busy is the acknowledge and stays high until
// the done cycle ends. Requests made while busy=1, or with op 6/7, are
// dropped, not queued.
//
// Signals:
//   start, op         requester -> sequencer   run request, golden function select
//   gate_in           sequencer -> GUT         registered input vector
//   gate_out          GUT -> sequencer         gate output under test
//   busy, done, pass  sequencer -> requester   run status
//   err_count         sequencer -> requester   saturating mismatch count
//   first_fail_*      sequencer -> requester   first failing vector (only with
//                                              GATE_SEQ_FAIL_CAPTURE_EN)
//
// Modports: master = sequencer side, slave = requester/GUT side.
interface gate_test_sequencer_if #(
    parameter int N_IN  = 2,
    parameter int ERR_W = 8
);
    logic             start;
    logic [2:0]       op;
    logic [N_IN-1:0]  gate_in;
    logic             gate_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    logic             first_fail_valid;
    logic [N_IN-1:0]  first_fail_vec;

    modport master (
        input  start, op, gate_out,
        output gate_in, busy, done, pass, err_count, first_fail_valid, first_fail_vec
    );
    modport slave (
        output start, op, gate_out,
        input  gate_in, busy, done, pass, err_count, first_fail_valid, first_fail_vec
    );
`else
    modport master (
        input  start, op, gate_out,
        output gate_in, busy, done, pass, err_count
    );
    modport slave (
        output start, op, gate_out,
        input  gate_in, busy, done, pass, err_count
    );
`endif
endinterface

// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer
// -------------------
// Exhaustive stimulus/check controller for a single-output combinational
// gate. After an accepted start it drives every input vector in ascending
// order, waits SETTLE cycles, samples gate_out and compares it with the
// golden function chosen by the latched op. Reports done, pass and a
// saturating mismatch count.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        gate_test_sequencer_if.master (start/op/gate_in/gate_out/
//              busy/done/pass/err_count, plus first_fail_* when enabled)
//   dbg_state  current FSM state (IDLE=0, DRIVE=1, WAIT=2, CHECK=3, DONE=4)
//
// Parameters: N_IN (1..8) GUT inputs, SETTLE (1..255) wait cycles,
// ERR_W mismatch counter width.
//
// Optional feature macro: GATE_SEQ_FAIL_CAPTURE_EN adds first_fail_valid /
// first_fail_vec, recording the first mismatching vector of a run.
module gate_test_sequencer #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gate_test_sequencer_if.master bus,
    output logic [2:0]            dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [N_IN-1:0]  LAST_VEC  = '1;
    localparam logic [7:0]       SETTLE_LD = 8'(SETTLE);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    state_t           state, state_nx;
    logic [2:0]       op_q, op_nx;
    logic [7:0]       settle_cnt, settle_nx;
    logic [N_IN-1:0]  vec_q, vec_nx;
    logic             busy_q, busy_nx;
    logic             done_q, done_nx;
    logic             pass_q, pass_nx;
    logic [ERR_W-1:0] err_q, err_nx;
    logic             accept;
    logic             mismatch;
    logic             last_vec;
    logic             settle_last;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    logic             ffv_q, ffv_nx;
    logic [N_IN-1:0]  ffvec_q, ffvec_nx;
`endif

    // Reduction over all inputs; with N_IN=1 this degenerates to the bit
    // itself or its inverse, which is what a 1-input gate means.
    function automatic logic golden(input logic [2:0] f, input logic [N_IN-1:0] v);
        logic r;
        case (f)
            3'd0:    r = &v;
            3'd1:    r = |v;
            3'd2:    r = ~&v;
            3'd3:    r = ~|v;
            3'd4:    r = ^v;
            3'd5:    r = ~^v;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign accept      = bus.start && (bus.op <= 3'd5);
    assign mismatch    = bus.gate_out != golden(op_q, vec_q);
    assign last_vec    = vec_q == LAST_VEC;
    // The counter is loaded with SETTLE on leaving DRIVE, so WAIT ends on
    // the cycle where it reads 1.
    assign settle_last = settle_cnt <= 8'd1;

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= '0;
            settle_cnt <= '0;
            vec_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
            ffv_q      <= 1'b0;
            ffvec_q    <= '0;
`endif
        end else begin
            state      <= state_nx;
            op_q       <= op_nx;
            settle_cnt <= settle_nx;
            vec_q      <= vec_nx;
            busy_q     <= busy_nx;
            done_q     <= done_nx;
            pass_q     <= pass_nx;
            err_q      <= err_nx;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
            ffv_q      <= ffv_nx;
            ffvec_q    <= ffvec_nx;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_DRIVE;
            S_DRIVE: state_nx = S_WAIT;
            S_WAIT:  if (settle_last) state_nx = S_CHECK;
            S_CHECK: state_nx = last_vec ? S_DONE : S_DRIVE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        op_nx     = op_q;
        settle_nx = settle_cnt;
        vec_nx    = vec_q;
        busy_nx   = busy_q;
        done_nx   = 1'b0;
        pass_nx   = pass_q;
        err_nx    = err_q;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
        ffv_nx    = ffv_q;
        ffvec_nx  = ffvec_q;
`endif
        case (state)
            S_IDLE: begin
                if (accept) begin
                    op_nx   = bus.op;
                    vec_nx  = '0;
                    err_nx  = '0;
                    pass_nx = 1'b0;
                    busy_nx = 1'b1;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
                    ffv_nx   = 1'b0;
                    ffvec_nx = '0;
`endif
                end
            end
            S_DRIVE: settle_nx = SETTLE_LD;
            S_WAIT:  settle_nx = settle_cnt - 8'd1;
            S_CHECK: begin
                if (mismatch && (err_q != ERR_MAX)) err_nx = err_q + 1'b1;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
                if (mismatch && !ffv_q) begin
                    ffv_nx   = 1'b1;
                    ffvec_nx = vec_q;
                end
`endif
                // pass is decided from the count including this last check,
                // so it is valid in the same cycle as done.
                if (last_vec) begin
                    done_nx = 1'b1;
                    pass_nx = (err_nx == '0);
                end else begin
                    vec_nx = vec_q + 1'b1;
                end
            end
            S_DONE:  busy_nx = 1'b0;
            default: ;
        endcase
    end

    assign bus.gate_in   = vec_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_vec   = ffvec_q;
`endif
    assign dbg_state = state;
endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb_gate_test_sequencer
// ----------------------
// Three sequencer instances with different N_IN/SETTLE/ERR_W, each driving
// a truth-table GUT. Expected results come from a counting model of the
// gate functions and an arithmetic timing model of the vector walk.
module tb_gate_test_sequencer;
    localparam int N_OF[3]  = '{2, 3, 3};
    localparam int S_OF[3]  = '{2, 1, 3};
    localparam int EW_OF[3] = '{8, 8, 2};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic       start_s[3];
    logic [2:0] op_s[3];
    logic [7:0] tbl[3];
    logic [7:0] gin[3];
    logic       busy_o[3], done_o[3], pass_o[3];
    logic [7:0] err_o[3];
    logic [2:0] dbg0, dbg1, dbg2;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    logic       ffv_o[3];
    logic [7:0] ffvec_o[3];
`endif

    gate_test_sequencer_if #(.N_IN(2), .ERR_W(8)) if0();
    gate_test_sequencer_if #(.N_IN(3), .ERR_W(8)) if1();
    gate_test_sequencer_if #(.N_IN(3), .ERR_W(2)) if2();

    gate_test_sequencer #(.N_IN(2), .SETTLE(2), .ERR_W(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.master), .dbg_state(dbg0));
    gate_test_sequencer #(.N_IN(3), .SETTLE(1), .ERR_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.master), .dbg_state(dbg1));
    gate_test_sequencer #(.N_IN(3), .SETTLE(3), .ERR_W(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.master), .dbg_state(dbg2));

    assign if0.start = start_s[0];  assign if0.op = op_s[0];  assign if0.gate_out = tbl[0][if0.gate_in];
    assign if1.start = start_s[1];  assign if1.op = op_s[1];  assign if1.gate_out = tbl[1][if1.gate_in];
    assign if2.start = start_s[2];  assign if2.op = op_s[2];  assign if2.gate_out = tbl[2][if2.gate_in];

    assign gin[0] = 8'(if0.gate_in);  assign gin[1] = 8'(if1.gate_in);  assign gin[2] = 8'(if2.gate_in);
    assign busy_o[0] = if0.busy;  assign busy_o[1] = if1.busy;  assign busy_o[2] = if2.busy;
    assign done_o[0] = if0.done;  assign done_o[1] = if1.done;  assign done_o[2] = if2.done;
    assign pass_o[0] = if0.pass;  assign pass_o[1] = if1.pass;  assign pass_o[2] = if2.pass;
    assign err_o[0] = 8'(if0.err_count);  assign err_o[1] = 8'(if1.err_count);  assign err_o[2] = 8'(if2.err_count);
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    assign ffv_o[0] = if0.first_fail_valid;  assign ffv_o[1] = if1.first_fail_valid;  assign ffv_o[2] = if2.first_fail_valid;
    assign ffvec_o[0] = 8'(if0.first_fail_vec);  assign ffvec_o[1] = 8'(if1.first_fail_vec);  assign ffvec_o[2] = 8'(if2.first_fail_vec);
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Gate behaviour by counting ones: AND = all ones, OR = any one,
    // XOR = odd number of ones; the N-variants invert.
    function automatic bit ref_gate(input int op, input int n, input int v);
        int ones;
        ones = $countones(v);
        case (op)
            0:       return ones == n;
            1:       return ones != 0;
            2:       return ones != n;
            3:       return ones == 0;
            4:       return (ones % 2) == 1;
            default: return (ones % 2) == 0;
        endcase
    endfunction

    function automatic logic [7:0] good_tbl(input int op, input int n);
        logic [7:0] t;
        t = '0;
        for (int v = 0; v < (1 << n); v++) t[v] = ref_gate(op, n, v);
        return t;
    endfunction

    // One full run on instance i. After the accepting edge k, the sample
    // taken after edge k+j must show vector j/(SETTLE+2); done appears at
    // j = 2^N*(SETTLE+2) and busy drops one edge later.
    task automatic run(input int i, input int op, input string tag, input bit repulse);
        int n, s, ew, nvec, total, mism, first_bad, exp_err, exp_vec, done_at, ndone;
        bit seq_ok, busy_ok;
        n = N_OF[i]; s = S_OF[i]; ew = EW_OF[i];
        nvec = 1 << n;
        total = nvec * (s + 2);
        mism = 0; first_bad = -1;
        for (int v = 0; v < nvec; v++) begin
            if (tbl[i][v] != ref_gate(op, n, v)) begin
                mism++;
                if (first_bad < 0) first_bad = v;
            end
        end
        exp_err = (mism > (1 << ew) - 1) ? (1 << ew) - 1 : mism;
        chk({tag, "_idle_busy"}, 32'(busy_o[i]), 32'd0);
        start_s[i] = 1'b1;
        op_s[i] = 3'(op);
        @(negedge clk);
        start_s[i] = 1'b0;
        seq_ok = 1'b1; busy_ok = 1'b1; done_at = -1; ndone = 0;
        for (int j = 0; j < total + 6; j++) begin
            exp_vec = (j < total) ? j / (s + 2) : nvec - 1;
            if (gin[i] !== 8'(exp_vec)) seq_ok = 1'b0;
            if (busy_o[i] !== (j <= total)) busy_ok = 1'b0;
            if (done_o[i] === 1'b1) begin
                ndone++;
                if (done_at < 0) done_at = j;
            end
            if (j == total) chk({tag, "_pass_at_done"}, 32'(pass_o[i]), 32'(exp_err == 0));
            if (repulse && (j == 3 || j == total)) start_s[i] = 1'b1;
            if (repulse && (j == 5 || j == total + 1)) start_s[i] = 1'b0;
            @(negedge clk);
        end
        chk({tag, "_vec_seq"}, 32'(seq_ok), 32'd1);
        chk({tag, "_busy_window"}, 32'(busy_ok), 32'd1);
        chk({tag, "_done_latency"}, 32'(done_at), 32'(total));
        chk({tag, "_done_count"}, 32'(ndone), 32'd1);
        chk({tag, "_err_count"}, 32'(err_o[i]), 32'(exp_err));
        chk({tag, "_pass_held"}, 32'(pass_o[i]), 32'(exp_err == 0));
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
        chk({tag, "_ff_valid"}, 32'(ffv_o[i]), 32'(mism > 0));
        chk({tag, "_ff_vec"}, 32'(ffvec_o[i]), 32'((first_bad < 0) ? 0 : first_bad));
`endif
    endtask

    initial begin
        bit idle_ok;
        int ri, rop;
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0;
            op_s[i] = 3'd0;
            tbl[i] = 8'd0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", 32'(busy_o[i]), 32'd0);
            chk("rst_done", 32'(done_o[i]), 32'd0);
            chk("rst_pass", 32'(pass_o[i]), 32'd0);
            chk("rst_err", 32'(err_o[i]), 32'd0);
            chk("rst_gate_in", 32'(gin[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Reserved ops must not start a run.
        start_s[0] = 1'b1; op_s[0] = 3'd6;
        start_s[1] = 1'b1; op_s[1] = 3'd7;
        idle_ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (busy_o[0] !== 1'b0 || done_o[0] !== 1'b0 || gin[0] !== 8'd0) idle_ok = 1'b0;
            if (busy_o[1] !== 1'b0 || done_o[1] !== 1'b0 || gin[1] !== 8'd0) idle_ok = 1'b0;
        end
        start_s[0] = 1'b0; start_s[1] = 1'b0;
        chk("reserved_op_ignored", 32'(idle_ok), 32'd1);

        // Correct NAND gate.
        tbl[0] = good_tbl(2, 2);
        run(0, 2, "nand_ok", 1'b0);
        // Output stuck at 0 under NAND: vectors 0..2 mismatch.
        tbl[0] = 8'd0;
        run(0, 2, "nand_stuck0", 1'b0);
        // 3-input XOR, start re-pulsed mid-run and during done.
        tbl[1] = good_tbl(4, 3);
        run(1, 4, "xor3_repulse", 1'b1);
        // NAND gate checked as AND: 8 mismatches saturate a 2-bit counter.
        tbl[2] = good_tbl(2, 3);
        run(2, 0, "sat_err", 1'b0);

        // Reset during WAIT of vector 2 on a stuck-0 NAND run.
        tbl[0] = 8'd0;
        start_s[0] = 1'b1; op_s[0] = 3'd2;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_gate_in", 32'(gin[0]), 32'd2);
        chk("pre_rst_err", 32'(err_o[0]), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_o[0]), 32'd0);
        chk("mid_rst_gate_in", 32'(gin[0]), 32'd0);
        chk("mid_rst_err", 32'(err_o[0]), 32'd0);
        chk("mid_rst_pass", 32'(pass_o[0]), 32'd0);
        idle_ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done_o[0] !== 1'b0) idle_ok = 1'b0;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0) idle_ok = 1'b0;
        end
        chk("mid_rst_no_done", 32'(idle_ok), 32'd1);
        tbl[0] = good_tbl(2, 2);
        run(0, 2, "after_rst", 1'b0);

        // Randomized runs: random instance, op and either a correct or a
        // random truth table.
        repeat (10) begin
            ri = $urandom_range(0, 2);
            rop = $urandom_range(0, 5);
            if ($urandom_range(0, 1) == 1) tbl[ri] = good_tbl(rop, N_OF[ri]);
            else tbl[ri] = 8'($urandom);
            run(ri, rop, "rnd", 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/gate_test_sequencer.md
Name: gate_test_sequencer

Overview:
Self-checking stimulus controller for a single-output combinational gate under test (GUT), e.g. nand_gate. On a start pulse it walks every input combination in ascending binary order. For each vector it waits a settle interval, samples the GUT output and compares it against a golden function selected by op. It reports completion, pass/fail and a mismatch count, replacing hand-written per-gate stimulus blocks.

Parameters:
N_IN, 2, GUT input count; legal range 1..8.
SETTLE, 2, wait cycles between driving a vector and sampling; legal range 1..255.
ERR_W, 8, width of the mismatch counter.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin a run; sampled only in IDLE.
op  input  3  golden function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 reserved; latched on accepted start.
gate_in  output  N_IN  registered vector driven to the GUT inputs.
gate_out  input  1  GUT output.
busy  output  1  high from the accepted start until the DONE cycle ends.
done  output  1  one-cycle completion pulse.
pass  output  1  1 when the last completed run had zero mismatches; held until the next accepted start.
err_count  output  ERR_W  mismatches in the current/last run; saturating.

Behaviour:
- Reset (async, rst_n=0): state IDLE; gate_in=0, busy=0, done=0, pass=0, err_count=0, internal vector and settle counters 0. All outputs are registered.
- States: IDLE, DRIVE, WAIT, CHECK, DONE.
- IDLE: start=1 with op<=5 -> DRIVE. On that edge: gate_in=0, latch op, clear err_count and pass, set busy=1. If start=1 with op 6/7, start is ignored and the block stays IDLE.
- DRIVE: lasts 1 cycle; loads the settle counter with SETTLE -> WAIT.
- WAIT: lasts exactly SETTLE cycles, counting down -> CHECK.
- CHECK: lasts 1 cycle.
  - Compare gate_out with golden(op_latched, gate_in). The golden function is a reduction over all N_IN bits. For N_IN=1: AND/OR/XOR return the bit and NAND/NOR/XNOR return its inverse.
  - On mismatch, err_count increments on the exit edge and saturates at 2^ERR_W-1.
  - If gate_in == 2^N_IN-1 -> DONE; otherwise gate_in increments by 1 -> DRIVE.
- DONE: done=1 and pass=(err_count==0) for 1 cycle. Next edge -> IDLE with busy=0. gate_in holds the last vector.
- Latency: done is high in the cycle after the edge (k + 2^N_IN*(SETTLE+2)), where k is the edge that accepted start. Example: N_IN=2, SETTLE=2 gives 16 edges.
- start while busy, including during DONE, is ignored. start held high in IDLE after DONE begins a new run.
- gate_out is sampled only in CHECK; changes in other states are ignored.
- Reset mid-run: immediate return to reset values. No done pulse. pass=0.

Optional Feature:
Macro GATE_SEQ_FAIL_CAPTURE_EN.
- Defined: adds output first_fail_valid (1 bit) and output first_fail_vec (N_IN bits).
  - Both cleared on reset and on an accepted start.
  - On the first mismatch of a run: first_fail_vec=gate_in and first_fail_valid=1, set on the CHECK exit edge.
  - Later mismatches do not overwrite it. Values are held after DONE.
- Undefined: neither port exists; no capture logic.

Test Plan:
1. N_IN=2, SETTLE=2, correct NAND GUT, op=2, pulse start -> gate_in sequences 0,1,2,3; done pulses 16 edges after start; pass=1, err_count=0.
2. N_IN=2, GUT output stuck at 0, op=2 -> err_count=3, pass=0; with GATE_SEQ_FAIL_CAPTURE_EN: first_fail_vec=0, first_fail_valid=1.
3. N_IN=3, SETTLE=1, correct XOR GUT, op=4 -> 8 vectors, done 24 edges after start, pass=1; start re-pulsed during the run -> no restart, single done.
4. ERR_W=2, N_IN=3, NAND GUT checked with op=0 (AND, all 8 mismatch) -> err_count saturates at 3, pass=0.
5. op=6 with start=1 -> busy stays 0, no done, gate_in stays 0.
6. Assert rst_n=0 during WAIT of vector 2 -> busy, gate_in, err_count, pass go 0 asynchronously; no done pulse; a new start afterwards completes normally.
